// File: rtl/rob_pkg.sv
// Shared types and defaults for the reorder buffer.
package rob_pkg;

  localparam int ROB_W_DEF = 3;
  localparam logic [ROB_W_DEF:0] NON_DEP = {1'b1, {ROB_W_DEF{1'b0}}};

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic [4:0]  rd;
    logic        is_br;
    logic        pred_taken;
    logic        taken;
    logic [31:0] value;
    logic [31:0] alt_pc;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/count bookkeeping for the reorder buffer; a flush returns all pointers to zero.
module rob_ptr_ctrl #(
  parameter int W = 3
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         issue_fire_i,
  input  logic         commit_fire_i,
  input  logic         flush_i,
  output logic [W-1:0] head_o,
  output logic [W-1:0] tail_o,
  output logic [W:0]   count_o,
  output logic         full_o
);

  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic [W:0]   count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (issue_fire_i)  tail_d = tail_q + 1'b1;
      if (commit_fire_i) head_d = head_q + 1'b1;
      case ({issue_fire_i, commit_fire_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign count_o = count_q;
  assign full_o  = (count_q == (W+1)'(1 << W));

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, CDB writeback, one retirement per cycle, flush on mispredict.
// Optional ROB_PERF_COUNTERS_EN adds retirement and flush counters.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int RoB_WIDTH = ROB_W_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 issue_en,
  input  logic [4:0]           issue_rd,
  input  logic                 issue_is_br,
  input  logic                 issue_pred_taken,
  input  logic [31:0]          issue_alt_pc,
  output logic [RoB_WIDTH-1:0] issue_index,
  output logic                 rob_full,
  input  logic                 cdb_en,
  input  logic [RoB_WIDTH-1:0] cdb_index,
  input  logic [31:0]          cdb_value,
  input  logic                 cdb_taken,
  input  logic [RoB_WIDTH:0]   query_j,
  input  logic [RoB_WIDTH:0]   query_k,
  output logic                 query_j_ready,
  output logic                 query_k_ready,
  output logic [31:0]          query_j_value,
  output logic [31:0]          query_k_value,
  output logic                 RoB_update_en,
  output logic [4:0]           RoB_update_reg,
  output logic [RoB_WIDTH-1:0] RoB_update_index,
  output logic [31:0]          RoB_update_data,
`ifdef ROB_PERF_COUNTERS_EN
  output logic [31:0]          perf_commit_cnt,
  output logic [31:0]          perf_flush_cnt,
`endif
  output logic                 flush_signal,
  output logic [31:0]          flush_pc
);

  localparam int ROB_SIZE = 1 << RoB_WIDTH;

  rob_entry_t ent_q [ROB_SIZE];

  logic [RoB_WIDTH-1:0] head, tail;
  logic [RoB_WIDTH:0]   count;
  logic                 full;
  logic                 upd_en_q, flush_q;
  logic [4:0]           upd_reg_q;
  logic [RoB_WIDTH-1:0] upd_idx_q;
  logic [31:0]          upd_data_q, flush_pc_q;

  logic issue_fire, cdb_fire, commit_fire, mispredict, flush_now;

  // The flush cycle itself is dead: nothing allocates, writes back or retires.
  assign issue_fire  = rdy_in && !flush_q && issue_en && !full;
  assign cdb_fire    = rdy_in && !flush_q && cdb_en && ent_q[cdb_index].busy;
  assign commit_fire = rdy_in && !flush_q && ent_q[head].busy && ent_q[head].ready;
  assign mispredict  = ent_q[head].is_br && (ent_q[head].taken != ent_q[head].pred_taken);
  assign flush_now   = commit_fire && mispredict;

  rob_ptr_ctrl #(.W(RoB_WIDTH)) u_ptr (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .issue_fire_i  (issue_fire),
    .commit_fire_i (commit_fire),
    .flush_i       (flush_now),
    .head_o        (head),
    .tail_o        (tail),
    .count_o       (count),
    .full_o        (full)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < ROB_SIZE; i++) ent_q[i] <= '0;
      upd_en_q   <= 1'b0;
      upd_reg_q  <= '0;
      upd_idx_q  <= '0;
      upd_data_q <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else if (rdy_in) begin
      upd_en_q <= 1'b0;
      flush_q  <= 1'b0;
      if (issue_fire)
        ent_q[tail] <= '{busy: 1'b1, ready: 1'b0, rd: issue_rd, is_br: issue_is_br,
                         pred_taken: issue_pred_taken, taken: 1'b0, value: 32'h0,
                         alt_pc: issue_alt_pc};
      if (cdb_fire) begin
        ent_q[cdb_index].ready <= 1'b1;
        ent_q[cdb_index].value <= cdb_value;
        ent_q[cdb_index].taken <= cdb_taken;
      end
      if (commit_fire) begin
        ent_q[head].busy <= 1'b0;
        if (!ent_q[head].is_br) begin
          upd_en_q   <= 1'b1;
          upd_reg_q  <= ent_q[head].rd;
          upd_idx_q  <= head;
          upd_data_q <= ent_q[head].value;
        end else if (mispredict) begin
          flush_q    <= 1'b1;
          flush_pc_q <= ent_q[head].alt_pc;
        end
      end
      // Squash everything younger; placed last so it overrides a same-edge issue.
      if (flush_now)
        for (int i = 0; i < ROB_SIZE; i++) ent_q[i].busy <= 1'b0;
    end
  end

`ifdef ROB_PERF_COUNTERS_EN
  logic [31:0] perf_commit_q, perf_flush_q;
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      perf_commit_q <= '0;
      perf_flush_q  <= '0;
    end else begin
      if (commit_fire) perf_commit_q <= perf_commit_q + 32'd1;
      if (flush_now)   perf_flush_q  <= perf_flush_q + 32'd1;
    end
  end
  assign perf_commit_cnt = perf_commit_q;
  assign perf_flush_cnt  = perf_flush_q;
`endif

  // Tag lookup; MSB set means the operand carries no dependency.
  logic [RoB_WIDTH-1:0] qj_idx, qk_idx;
  logic                 qj_fwd, qk_fwd;

  assign qj_idx = query_j[RoB_WIDTH-1:0];
  assign qk_idx = query_k[RoB_WIDTH-1:0];
  assign qj_fwd = !query_j[RoB_WIDTH] && cdb_en && (cdb_index == qj_idx);
  assign qk_fwd = !query_k[RoB_WIDTH] && cdb_en && (cdb_index == qk_idx);

  assign query_j_ready = query_j[RoB_WIDTH] || qj_fwd || ent_q[qj_idx].ready;
  assign query_k_ready = query_k[RoB_WIDTH] || qk_fwd || ent_q[qk_idx].ready;
  assign query_j_value = query_j[RoB_WIDTH] ? 32'h0 : qj_fwd ? cdb_value :
                         ent_q[qj_idx].ready ? ent_q[qj_idx].value : 32'h0;
  assign query_k_value = query_k[RoB_WIDTH] ? 32'h0 : qk_fwd ? cdb_value :
                         ent_q[qk_idx].ready ? ent_q[qk_idx].value : 32'h0;

  assign issue_index      = tail;
  assign rob_full         = full;
  assign RoB_update_en    = upd_en_q;
  assign RoB_update_reg   = upd_reg_q;
  assign RoB_update_index = upd_idx_q;
  assign RoB_update_data  = upd_data_q;
  assign flush_signal     = flush_q;
  assign flush_pc         = flush_pc_q;

  logic unused_ok;
  assign unused_ok = ^count;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;

  logic        clk_in = 0, rst_in = 1, rdy_in = 1;
  logic        issue_en = 0, issue_is_br = 0, issue_pred_taken = 0;
  logic [4:0]  issue_rd = 0;
  logic [31:0] issue_alt_pc = 0;
  logic [2:0]  issue_index;
  logic        rob_full;
  logic        cdb_en = 0, cdb_taken = 0;
  logic [2:0]  cdb_index = 0;
  logic [31:0] cdb_value = 0;
  logic [3:0]  query_j = 4'h8, query_k = 4'h8;
  logic        query_j_ready, query_k_ready;
  logic [31:0] query_j_value, query_k_value;
  logic        RoB_update_en;
  logic [4:0]  RoB_update_reg;
  logic [2:0]  RoB_update_index;
  logic [31:0] RoB_update_data;
  logic        flush_signal;
  logic [31:0] flush_pc;

  int vecs = 0, errs = 0;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_en(issue_en), .issue_rd(issue_rd), .issue_is_br(issue_is_br),
    .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
    .issue_index(issue_index), .rob_full(rob_full),
    .cdb_en(cdb_en), .cdb_index(cdb_index), .cdb_value(cdb_value), .cdb_taken(cdb_taken),
    .query_j(query_j), .query_k(query_k),
    .query_j_ready(query_j_ready), .query_k_ready(query_k_ready),
    .query_j_value(query_j_value), .query_k_value(query_k_value),
    .RoB_update_en(RoB_update_en), .RoB_update_reg(RoB_update_reg),
    .RoB_update_index(RoB_update_index), .RoB_update_data(RoB_update_data),
    .flush_signal(flush_signal), .flush_pc(flush_pc)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in); #1;
  endtask

  task automatic do_reset();
    rst_in = 1; step(); rst_in = 0;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic br, input logic pred, input logic [31:0] alt);
    issue_en = 1; issue_rd = rd; issue_is_br = br; issue_pred_taken = pred; issue_alt_pc = alt;
    step();
    issue_en = 0; issue_is_br = 0; issue_pred_taken = 0;
  endtask

  task automatic do_cdb(input logic [2:0] idx, input logic [31:0] val, input logic tk);
    cdb_en = 1; cdb_index = idx; cdb_value = val; cdb_taken = tk;
    step();
    cdb_en = 0; cdb_taken = 0;
  endtask

  task automatic test_reset();
    do_reset();
    do_issue(5'd1, 0, 0, 0); do_issue(5'd2, 0, 0, 0); do_issue(5'd3, 0, 0, 0);
    vecs++; if (issue_index !== 3'd3) begin errs++; $display("FAIL pre_reset_tail: got %0d want 3", issue_index); end
    rst_in = 1; step(); rst_in = 0;
    vecs++; if (rob_full !== 1'b0) begin errs++; $display("FAIL reset_full: got %0b want 0", rob_full); end
    vecs++; if (issue_index !== 3'd0) begin errs++; $display("FAIL reset_tail: got %0d want 0", issue_index); end
    vecs++; if (RoB_update_en !== 1'b0) begin errs++; $display("FAIL reset_upd_en: got %0b want 0", RoB_update_en); end
    vecs++; if (flush_signal !== 1'b0) begin errs++; $display("FAIL reset_flush: got %0b want 0", flush_signal); end
  endtask

  task automatic test_commit();
    do_reset();
    vecs++; if (issue_index !== 3'd0) begin errs++; $display("FAIL commit_issue_idx: got %0d want 0", issue_index); end
    do_issue(5'd5, 0, 0, 0);
    do_cdb(3'd0, 32'h1234, 0);
    vecs++; if (RoB_update_en !== 1'b0) begin errs++; $display("FAIL commit_early: got %0b want 0", RoB_update_en); end
    step();
    vecs++; if (RoB_update_en !== 1'b1) begin errs++; $display("FAIL commit_en: got %0b want 1", RoB_update_en); end
    vecs++; if (RoB_update_reg !== 5'd5) begin errs++; $display("FAIL commit_reg: got %0d want 5", RoB_update_reg); end
    vecs++; if (RoB_update_index !== 3'd0) begin errs++; $display("FAIL commit_idx: got %0d want 0", RoB_update_index); end
    vecs++; if (RoB_update_data !== 32'h1234) begin errs++; $display("FAIL commit_data: got %0h want 1234", RoB_update_data); end
    step();
    vecs++; if (RoB_update_en !== 1'b0) begin errs++; $display("FAIL commit_pulse: got %0b want 0", RoB_update_en); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) do_issue(5'(i + 1), 0, 0, 0);
    vecs++; if (rob_full !== 1'b1) begin errs++; $display("FAIL full_set: got %0b want 1", rob_full); end
    do_issue(5'd20, 0, 0, 0);
    vecs++; if (issue_index !== 3'd0) begin errs++; $display("FAIL full_ignore_idx: got %0d want 0", issue_index); end
    vecs++; if (rob_full !== 1'b1) begin errs++; $display("FAIL full_hold: got %0b want 1", rob_full); end
    do_cdb(3'd0, 32'h11, 0);
    issue_en = 1; issue_rd = 5'd9;
    step();
    issue_en = 0;
    vecs++; if (rob_full !== 1'b0) begin errs++; $display("FAIL full_commit_cnt7: got %0b want 0", rob_full); end
    vecs++; if (issue_index !== 3'd0) begin errs++; $display("FAIL full_blocked_idx: got %0d want 0", issue_index); end
    vecs++; if (RoB_update_data !== 32'h11) begin errs++; $display("FAIL full_commit_data: got %0h want 11", RoB_update_data); end
    do_issue(5'd9, 0, 0, 0);
    vecs++; if (rob_full !== 1'b1) begin errs++; $display("FAIL full_refill: got %0b want 1", rob_full); end
  endtask

  task automatic test_flush();
    do_reset();
    do_issue(5'd1, 0, 0, 0); do_issue(5'd2, 0, 0, 0);
    do_issue(5'd0, 1, 0, 32'h80);
    for (int i = 3; i < 8; i++) do_issue(5'(i), 0, 0, 0);
    for (int i = 3; i < 8; i++) do_cdb(3'(i), 32'(i * 16), 0);
    do_cdb(3'd2, 32'h0, 1);
    do_cdb(3'd0, 32'hA0, 0);
    do_cdb(3'd1, 32'hA1, 0);
    vecs++; if (RoB_update_reg !== 5'd1) begin errs++; $display("FAIL flush_pre0: got %0d want 1", RoB_update_reg); end
    step();
    vecs++; if (RoB_update_reg !== 5'd2) begin errs++; $display("FAIL flush_pre1: got %0d want 2", RoB_update_reg); end
    step();
    vecs++; if (flush_signal !== 1'b1) begin errs++; $display("FAIL flush_sig: got %0b want 1", flush_signal); end
    vecs++; if (flush_pc !== 32'h80) begin errs++; $display("FAIL flush_pc: got %0h want 80", flush_pc); end
    vecs++; if (RoB_update_en !== 1'b0) begin errs++; $display("FAIL flush_upd_en: got %0b want 0", RoB_update_en); end
    issue_en = 1; issue_rd = 5'd9;
    step();
    issue_en = 0;
    vecs++; if (flush_signal !== 1'b0) begin errs++; $display("FAIL flush_pulse: got %0b want 0", flush_signal); end
    vecs++; if (issue_index !== 3'd0) begin errs++; $display("FAIL flush_issue_ignored: got %0d want 0", issue_index); end
    for (int i = 0; i < 4; i++) begin
      step();
      vecs++; if (RoB_update_en !== 1'b0) begin errs++; $display("FAIL flush_no_commit: got %0b want 0", RoB_update_en); end
    end
  endtask

  task automatic test_query();
    do_reset();
    for (int i = 0; i < 5; i++) do_issue(5'(i + 1), 0, 0, 0);
    query_j = 4'd4; query_k = 4'h8; #1;
    vecs++; if (query_j_ready !== 1'b0) begin errs++; $display("FAIL query_not_ready: got %0b want 0", query_j_ready); end
    cdb_en = 1; cdb_index = 3'd4; cdb_value = 32'hAA; #1;
    vecs++; if (query_j_ready !== 1'b1) begin errs++; $display("FAIL query_fwd_rdy: got %0b want 1", query_j_ready); end
    vecs++; if (query_j_value !== 32'hAA) begin errs++; $display("FAIL query_fwd_val: got %0h want aa", query_j_value); end
    vecs++; if (query_k_ready !== 1'b1) begin errs++; $display("FAIL query_nodep_rdy: got %0b want 1", query_k_ready); end
    vecs++; if (query_k_value !== 32'h0) begin errs++; $display("FAIL query_nodep_val: got %0h want 0", query_k_value); end
    step(); cdb_en = 0; #1;
    vecs++; if (query_j_value !== 32'hAA) begin errs++; $display("FAIL query_stored_val: got %0h want aa", query_j_value); end
    query_j = 4'h8;
  endtask

  task automatic test_pause();
    do_reset();
    do_issue(5'd7, 0, 0, 0); do_issue(5'd8, 0, 0, 0);
    do_cdb(3'd0, 32'h55, 0);
    do_cdb(3'd1, 32'h66, 0);
    rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      vecs++; if (RoB_update_en !== 1'b1) begin errs++; $display("FAIL pause_en: got %0b want 1", RoB_update_en); end
      vecs++; if (RoB_update_reg !== 5'd7) begin errs++; $display("FAIL pause_reg: got %0d want 7", RoB_update_reg); end
      vecs++; if (RoB_update_data !== 32'h55) begin errs++; $display("FAIL pause_data: got %0h want 55", RoB_update_data); end
      step();
    end
    vecs++; if (RoB_update_reg !== 5'd7) begin errs++; $display("FAIL pause_frozen: got %0d want 7", RoB_update_reg); end
    rdy_in = 1;
    step();
    vecs++; if (RoB_update_en !== 1'b1) begin errs++; $display("FAIL resume_en: got %0b want 1", RoB_update_en); end
    vecs++; if (RoB_update_index !== 3'd1) begin errs++; $display("FAIL resume_idx: got %0d want 1", RoB_update_index); end
    vecs++; if (RoB_update_data !== 32'h66) begin errs++; $display("FAIL resume_data: got %0h want 66", RoB_update_data); end
    step();
    vecs++; if (RoB_update_en !== 1'b0) begin errs++; $display("FAIL resume_pulse: got %0b want 0", RoB_update_en); end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_full();
    test_flush();
    test_query();
    test_pause();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Circular reorder buffer that allocates entries in program order from the Dispatcher and collects results from the CDB. It retires one ready entry per cycle to the register file.
It drives the RF commit interface (RoB_update_*) and the global flush_signal on branch mispredict. It is the producer end of the RoB→RF protocol; the RF consumes it.

Parameters:
RoB_WIDTH, 3, log2 of entry count; indices are RoB_WIDTH bits
ROB_SIZE, 1 << RoB_WIDTH, entry count
NON_DEP, 1 << RoB_WIDTH, "no dependency" tag (valid bit set, index 0)

Ports:
clk_in  input  1  clock
rst_in  input  1  reset, asynchronous, active-high
rdy_in  input  1  global enable; 0 = pause, all state holds
issue_en  input  1  Dispatcher allocates an entry this cycle
issue_rd  input  5  destination register; 0 = none
issue_is_br  input  1  entry is a conditional branch
issue_pred_taken  input  1  predicted direction
issue_alt_pc  input  32  recovery PC if prediction wrong
issue_index  output  RoB_WIDTH  tail index; valid when issue_en && !rob_full
rob_full  output  1  count == ROB_SIZE
cdb_en  input  1  execution result broadcast
cdb_index  input  RoB_WIDTH  producing entry
cdb_value  input  32  result value
cdb_taken  input  1  actual branch outcome
query_j, query_k  input  RoB_WIDTH+1 each  Dispatcher tag lookup; MSB set = no lookup
query_j_ready, query_k_ready  output  1 each  entry value available
query_j_value, query_k_value  output  32 each  entry value or CDB-forwarded value
RoB_update_en  output  1  commit pulse to RF
RoB_update_reg  output  5  committed rd
RoB_update_index  output  RoB_WIDTH  committed entry index
RoB_update_data  output  32  committed value
flush_signal  output  1  mispredict flush pulse
flush_pc  output  32  fetch redirect target, valid with flush_signal

Behaviour:
- Per-entry state: busy, ready, rd, is_br, pred_taken, value, alt_pc. Pointers head, tail (RoB_WIDTH, wrap naturally); count is RoB_WIDTH+1 bits.
- Reset (async): head = tail = count = 0, all busy/ready = 0. All registered outputs are 0: RoB_update_*, flush_signal, flush_pc.
- rdy_in = 0: no state or output register changes.
- Issue: if issue_en && !rob_full, write the entry at tail with busy=1, ready=0, then tail+1.
  - rob_full uses the current count. Issue is blocked when full even if a commit occurs the same cycle.
  - issue_en while full is ignored; the Dispatcher must hold.
- CDB: if cdb_en and entry[cdb_index].busy, set ready=1, value=cdb_value, and store cdb_taken. CDB to a non-busy entry is ignored.
- Commit (one per cycle, registered, 1-cycle latency): if entry[head].busy && ready, clear busy and advance head.
  - Non-branch: next cycle RoB_update_en=1, reg=rd, index=head, data=value. rd=0 still pulses with reg=0; the RF ignores it.
  - Branch, correct prediction: retire silently, RoB_update_en=0.
  - Branch, mispredicted (taken != pred_taken): next cycle flush_signal=1 and flush_pc=alt_pc. Same edge: head=tail=count=0 and all busy cleared. RoB_update_en=0.
- Otherwise RoB_update_en and flush_signal are 0; they are single-cycle pulses.
- While flush_signal=1 (flush cycle): issue_en and cdb_en are ignored; no commit.
- count update: +1 on issue, -1 on commit, unchanged when both occur.
- Query (combinational):
  - ready = 1 if the tag MSB is set, or entry.ready, or (cdb_en && cdb_index == tag).
  - value = CDB value if forwarding, else entry.value, else 0.
  - A query on a tag being committed in the same cycle still returns the entry value.

Optional Feature:
ROB_PERF_COUNTERS_EN
- Defined: add outputs perf_commit_cnt[31:0] (non-branch and branch retirements) and perf_flush_cnt[31:0] (flush pulses). Both reset to 0, wrap at 2^32, and hold when rdy_in=0.
- Undefined: ports and logic are absent.

Decomposition:
- Package rob_pkg: RoB_WIDTH default, NON_DEP, and an entry struct/typedef of field widths.
- Sub-module rob_ptr_ctrl: head/tail/count update, full flag, flush reset of pointers.
- Entry array and commit/flush logic stay in reorder_buffer.

Test Plan:
- Reset mid-run with 3 busy entries → next clock rob_full=0, issue_index=0, RoB_update_en=0, flush_signal=0.
- Issue rd=5 at idx 0; CDB idx 0 value 0x1234 → one cycle later RoB_update_en=1, reg=5, index=0, data=0x1234; the next cycle RoB_update_en=0.
- Issue 8 entries → rob_full=1; 9th issue_en ignored (issue_index still 0). Commit one and issue the same cycle → issue blocked, count 7.
- Branch at idx 2, pred_taken=0, alt_pc=0x80; CDB cdb_taken=1 → on reaching head, flush_signal=1, flush_pc=0x80; next cycle issue_index=0 and entries 3..7 never commit.
- query_j=idx 4 (not ready) with cdb_en idx 4 value 0xAA the same cycle → query_j_ready=1, value=0xAA. query_k MSB set → ready=1, value=0.
- rdy_in=0 for 3 cycles while a commit pulse is active → RoB_update_* held unchanged and head frozen; resumes correctly.
